// File: rtl/rng_byte_server_if.sv
// rng_byte_server_if: CPU request/response and LFSR control bundle for rng_byte_server
interface rng_byte_server_if;
  logic       req_i;
  logic [7:0] mask_i;
  logic       busy_o;
  logic       valid_o;
  logic [7:0] rand_o;
  logic       lock_err_o;
  logic       lfsr_enable_o;
  logic [7:0] lfsr_out_i;
  modport master (
    output req_i, mask_i, lfsr_out_i,
    input  busy_o, valid_o, rand_o, lock_err_o, lfsr_enable_o
  );
  modport slave (
    input  req_i, mask_i, lfsr_out_i,
    output busy_o, valid_o, rand_o, lock_err_o, lfsr_enable_o
  );
endinterface

// File: rtl/rng_byte_server.sv
// rng_byte_server: steps the LFSR a fixed number of times per request and returns a masked random byte
module rng_byte_server #(
  parameter int STEPS = 8,
  parameter bit STIR  = 1'b0
) (
  input logic               clk,
  input logic               reset,
  rng_byte_server_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, SAMPLE} state_t;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, mask_q, mask_d, rand_q, rand_d;
  logic       valid_q, valid_d, lock_q, lock_d;
  // accept a request, run the LFSR for STEPS cycles, then sample, mask and pulse valid
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    rand_d  = rand_q;
    valid_d = 1'b0;
    lock_d  = lock_q;
    case (state_q)
      IDLE: if (bus.req_i) begin
        mask_d  = bus.mask_i;
        cnt_d   = 8'(STEPS);
        state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d   = cnt_q - 8'd1;
        state_d = (cnt_q == 8'd1) ? SAMPLE : SHIFT;
      end
      SAMPLE: begin
        rand_d  = bus.lfsr_out_i & mask_q;
        valid_d = 1'b1;
        lock_d  = lock_q | (bus.lfsr_out_i == 8'h00);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and result registers; reset aborts any request in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'h00;
      mask_q  <= 8'h00;
      rand_q  <= 8'h00;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      rand_q  <= rand_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
    end
  end
  assign bus.busy_o        = state_q != IDLE;
  assign bus.valid_o       = valid_q;
  assign bus.rand_o        = rand_q;
  assign bus.lock_err_o    = lock_q;
  assign bus.lfsr_enable_o = ~reset & ((state_q == SHIFT) | (STIR & (state_q == IDLE)));
endmodule
